imem_loader: RTL

- Instruction-memory block directly upstream of the MIPS core's fetch stage.
- Holds the DEPTH x 32 instruction store and serves the core's fetch port with an asynchronous read.
- Fills the store from a byte stream (UART receiver, valid/ready) and holds the core in reset until a complete, valid image is loaded.

---
 rtl/imem_loader.sv | 139 +++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// Instruction store for the MIPS core, filled from a UART byte stream; holds the core in reset until loaded.
// Optional trailing XOR checksum byte is enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
   parameter int ADDR_W = 10,
   parameter int DEPTH  = 1 << ADDR_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              rx_ready,
   input  logic              load_req,
   input  logic [ADDR_W-1:0] inst_addr,
   output logic [31:0]       inst_out,
   output logic              cpu_reset,
   output logic              loading,
   output logic              load_done,
   output logic              load_error,
   output logic [ADDR_W:0]   words_loaded
);

   typedef enum logic [2:0] {
      S_LEN   = 3'd0,
      S_DATA  = 3'd1,
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHECK = 3'd2,
`endif
      S_RUN   = 3'd3,
      S_ERROR = 3'd4
   } state_t;

   state_t            state, state_next;
   logic [1:0]        byte_cnt;
   logic [ADDR_W:0]   word_cnt;
   logic [15:0]       len;
   logic [23:0]       word_reg;
   logic [31:0]       mem [DEPTH];
   logic              accept;
   logic [15:0]       n_rx;
   logic              len_bad;
   logic              last_word;
   logic              word_wr;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0]        chk;
`endif

   assign accept    = rx_valid && rx_ready;
   assign n_rx      = {len[15:8], rx_data};
   assign len_bad   = (n_rx == 16'd0) || (17'(n_rx) > 17'(DEPTH));
   assign last_word = (17'(word_cnt) + 17'd1) == 17'(len);
   // load_req and reset both discard a byte arriving on the same edge
   assign word_wr   = !reset && !load_req && accept && (state == S_DATA) && (byte_cnt == 2'd3);

   always_ff @(posedge clk) begin
      if (reset) state <= S_LEN;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      if (load_req) begin
         state_next = S_LEN;
      end else if (accept) begin
         case (state)
            S_LEN:  if (byte_cnt[0]) state_next = len_bad ? S_ERROR : S_DATA;
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_DATA:  if (byte_cnt == 2'd3 && last_word) state_next = S_CHECK;
            S_CHECK: state_next = (rx_data == chk) ? S_RUN : S_ERROR;
`else
            S_DATA:  if (byte_cnt == 2'd3 && last_word) state_next = S_RUN;
`endif
            default: ;
         endcase
      end
   end

   always_comb begin
      cpu_reset  = 1'b1;
      rx_ready   = 1'b0;
      loading    = 1'b0;
      load_done  = 1'b0;
      load_error = 1'b0;
      case (state)
         S_LEN, S_DATA: begin
            rx_ready = 1'b1;
            loading  = 1'b1;
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         S_CHECK: begin
            rx_ready = 1'b1;
            loading  = 1'b1;
         end
`endif
         S_RUN: begin
            cpu_reset = 1'b0;
            load_done = 1'b1;
         end
         S_ERROR: load_error = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset || load_req) begin
         byte_cnt <= 2'd0;
         word_cnt <= '0;
         len      <= 16'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         chk      <= 8'd0;
`endif
      end else if (accept) begin
         case (state)
            S_LEN: begin
               if (byte_cnt[0]) len[7:0]  <= rx_data;
               else             len[15:8] <= rx_data;
               byte_cnt <= byte_cnt[0] ? 2'd0 : 2'd1;
            end
            S_DATA: begin
               byte_cnt <= byte_cnt + 2'd1;
               if (byte_cnt == 2'd3) word_cnt <= word_cnt + 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
               chk <= chk ^ rx_data;
`endif
            end
            default: ;
         endcase
      end
   end

   // Byte-assembly and storage carry no reset; stale contents are harmless
   always_ff @(posedge clk) begin
      if (accept && state == S_DATA) word_reg <= {word_reg[15:0], rx_data};
      if (word_wr) mem[word_cnt[ADDR_W-1:0]] <= {word_reg, rx_data};
   end

   assign inst_out     = mem[inst_addr];
   assign words_loaded = word_cnt;

endmodule
